// File: rtl/da_fir_pkg.sv
// -----------------------------------------------------------------------------
// da_fir_pkg
//   Definitions shared across the distributed-arithmetic FIR datapath:
//   - DEF_IN_W / DEF_NBITS : default carry-save slice width and bit-slices
//                            per output sample
//   - da_state_t           : state encoding of the shift-accumulate FSM
//   - calc_out_w()         : result width derivation (IN_W + NBITS + 2)
// -----------------------------------------------------------------------------
package da_fir_pkg;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_NBITS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } da_state_t;

  // Two guard bits cover the 3*2^IN_W slice range plus the sign of the
  // MSB-weighted slice after NBITS-1 doublings.
  function automatic int calc_out_w(input int in_w, input int nbits);
    return in_w + nbits + 2;
  endfunction

endpackage

// File: rtl/da_cs_resolve.sv
// -----------------------------------------------------------------------------
// da_cs_resolve
//   Collapses one carry-save slice from the 4:2 compressor into a single
//   unsigned value: v = s_in + 2*c_in + cout_in*2^IN_W, zero-extended.
//
//   Ports
//     s_in    in  IN_W   sum word
//     c_in    in  IN_W   carry word (weight 2)
//     cout_in in  1      top carry-out (weight 2^IN_W)
//     v       out OUT_W  resolved slice value
// -----------------------------------------------------------------------------
module da_cs_resolve
  import da_fir_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = calc_out_w(DEF_IN_W, DEF_NBITS)
) (
  input  logic [IN_W-1:0]  s_in,
  input  logic [IN_W-1:0]  c_in,
  input  logic             cout_in,
  output logic [OUT_W-1:0] v
);

  always_comb begin
    v = OUT_W'(s_in) + (OUT_W'(c_in) << 1) + (OUT_W'(cout_in) << IN_W);
  end

endmodule

// File: rtl/da_shift_acc.sv
// -----------------------------------------------------------------------------
// da_shift_acc
//   Shift-accumulate stage of a bit-serial distributed-arithmetic FIR.
//   Receives NBITS carry-save slices per output sample, MSB (sign) slice
//   first, and builds the signed result
//     y = -V[NBITS-1]*2^(NBITS-1) + sum_{b<NBITS-1} V[b]*2^b
//   by seeding the accumulator with -V and then doubling-and-adding.
//   The finished result sits in a one-deep output register with a
//   valid/ready handshake; an unaccepted result that gets replaced raises
//   the sticky ovr flag.
//
//   Ports
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     s_in       in   IN_W   compressor sum word
//     c_in       in   IN_W   compressor carry word
//     cout_in    in   1      compressor top carry-out
//     in_valid   in   1      slice qualifier (no backpressure)
//     in_first   in   1      first (MSB/sign) slice of a sample
//     out_data   out  OUT_W  signed result
//     out_valid  out  1      result available
//     out_ready  in   1      consumer accepts out_data
//     ovr        out  1      sticky: result overwritten before acceptance
//     frame_err  out  1      sticky: framing violation seen
//     err_clr    in   1      synchronous clear of ovr/frame_err (wins over set)
// -----------------------------------------------------------------------------
module da_shift_acc
  import da_fir_pkg::*;
#(
  parameter  int IN_W  = DEF_IN_W,
  parameter  int NBITS = DEF_NBITS,
  localparam int OUT_W = calc_out_w(IN_W, NBITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         s_in,
  input  logic [IN_W-1:0]         c_in,
  input  logic                    cout_in,
  input  logic                    in_valid,
  input  logic                    in_first,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovr,
  output logic                    frame_err,
  input  logic                    err_clr
);

  localparam int              CNT_W    = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  // ---------------------------------------------------------------------------
  // Slice resolution
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] slice_v;

  da_cs_resolve #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_cs_resolve (
    .s_in    (s_in),
    .c_in    (c_in),
    .cout_in (cout_in),
    .v       (slice_v)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  da_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic [OUT_W-1:0] acc_step;
  logic             load_res;
  logic             frame_set;

  // Modular OUT_W arithmetic is exact here: the true result always fits.
  assign acc_step = (acc << 1) + slice_v;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    load_res  = 1'b0;
    frame_set = 1'b0;

    if (in_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (in_first) begin
            acc_nxt   = OUT_W'(0) - slice_v;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ST_ACC;
          end else begin
            // Stray slice with no sample open: drop it.
            frame_set = 1'b1;
          end
        end

        ST_ACC: begin
          if (in_first) begin
            // A new sign slice mid-sample abandons the partial sample.
            frame_set = 1'b1;
            acc_nxt   = OUT_W'(0) - slice_v;
            cnt_nxt   = CNT_W'(1);
          end else begin
            acc_nxt = acc_step;
            if (cnt == LAST_CNT) begin
              load_res  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = ST_IDLE;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt_nxt;
      acc <= acc_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, handshake and sticky flags
  // ---------------------------------------------------------------------------
  logic out_valid_nxt;
  logic ovr_nxt;
  logic frame_err_nxt;

  always_comb begin
    // A load keeps out_valid high even when the old result is taken on
    // the same edge; otherwise acceptance drops it.
    out_valid_nxt = load_res | (out_valid & ~out_ready);
    ovr_nxt       = err_clr ? 1'b0 : (ovr | (load_res & out_valid & ~out_ready));
    frame_err_nxt = err_clr ? 1'b0 : (frame_err | frame_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovr       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_res) begin
        out_data <= acc_step;
      end
      out_valid <= out_valid_nxt;
      ovr       <= ovr_nxt;
      frame_err <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_da_shift_acc.sv
// -----------------------------------------------------------------------------
// tb_da_shift_acc
//   Directed bench for da_shift_acc with IN_W=4, NBITS=4 (OUT_W=10).
//   Inputs change 1 time unit after the rising edge; outputs are checked at
//   that same point, i.e. showing the state loaded by the preceding edge.
// -----------------------------------------------------------------------------
module tb_da_shift_acc;

  localparam int IN_W  = 4;
  localparam int NBITS = 4;
  localparam int OUT_W = IN_W + NBITS + 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [IN_W-1:0]         s_in;
  logic [IN_W-1:0]         c_in;
  logic                    cout_in;
  logic                    in_valid;
  logic                    in_first;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    ovr;
  logic                    frame_err;
  logic                    err_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  da_shift_acc #(
    .IN_W  (IN_W),
    .NBITS (NBITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .c_in      (c_in),
    .cout_in   (cout_in),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovr       (ovr),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One slice for one cycle; the next call keeps it back-to-back.
  task automatic slice(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c,
                       input logic co, input logic f);
    s_in     = s;
    c_in     = c;
    cout_in  = co;
    in_first = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  // V = 1,0,1,1 -> y = -8 + 2 + 1 = -5
  task automatic sample_m5(input int gap);
    slice(4'd1, 4'd0, 1'b0, 1'b1); idle(gap);
    slice(4'd0, 4'd0, 1'b0, 1'b0); idle(gap);
    slice(4'd1, 4'd0, 1'b0, 1'b0); idle(gap);
    slice(4'd1, 4'd0, 1'b0, 1'b0);
  endtask

  // V = 5,16,0,0 -> y = -40 + 64 = 24
  task automatic sample_24();
    slice(4'd3, 4'd1, 1'b0, 1'b1);
    slice(4'd0, 4'd0, 1'b1, 1'b0);
    slice(4'd0, 4'd0, 1'b0, 1'b0);
    slice(4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b1;
    s_in      = '0;
    c_in      = '0;
    cout_in   = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    idle(2);
    check("rst_out_data",  out_data,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ovr",       ovr,       0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back sample, -5, one-cycle valid
    slice(4'd1, 4'd0, 1'b0, 1'b1);
    slice(4'd0, 4'd0, 1'b0, 1'b0);
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    check("b2b_valid_early", out_valid, 0);
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    check("b2b_valid",  out_valid, 1);
    check("b2b_data",   out_data,  -5);
    tick();
    check("b2b_valid_1cyc", out_valid, 0);

    // Carry-save resolution: V=5 and V=16 -> 24
    sample_24();
    check("cs_valid", out_valid, 1);
    check("cs_data",  out_data,  24);
    tick();

    // Gapped slices
    slice(4'd1, 4'd0, 1'b0, 1'b1); idle(3);
    slice(4'd0, 4'd0, 1'b0, 1'b0); idle(3);
    slice(4'd1, 4'd0, 1'b0, 1'b0); idle(3);
    check("gap_valid_mid", out_valid, 0);
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    check("gap_valid", out_valid, 1);
    check("gap_data",  out_data,  -5);
    check("gap_ferr",  frame_err, 0);
    check("gap_ovr",   ovr,       0);
    tick();

    // Hold while not ready, then overwrite
    out_ready = 1'b0;
    sample_m5(0);
    check("hold_valid0", out_valid, 1);
    check("hold_ovr0",   ovr,       0);
    idle(2);
    check("hold_valid", out_valid, 1);
    check("hold_data",  out_data,  -5);
    sample_24();
    check("ovw_data",  out_data,  24);
    check("ovw_valid", out_valid, 1);
    check("ovw_ovr",   ovr,       1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_ovr",   ovr,       0);
    check("clr_valid", out_valid, 1);

    // Load coinciding with acceptance: no overrun
    slice(4'd1, 4'd0, 1'b0, 1'b1);
    slice(4'd0, 4'd0, 1'b0, 1'b0);
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    check("acc_ld_valid", out_valid, 1);
    check("acc_ld_data",  out_data,  -5);
    check("acc_ld_ovr",   ovr,       0);
    tick();
    check("acc_ld_drop", out_valid, 0);

    // Framing: in_first on the 3rd slice restarts the sample
    slice(4'd1, 4'd0, 1'b0, 1'b1);
    slice(4'd0, 4'd0, 1'b0, 1'b0);
    check("frm_ferr0", frame_err, 0);
    slice(4'd1, 4'd0, 1'b0, 1'b1);
    check("frm_ferr1", frame_err, 1);
    slice(4'd0, 4'd0, 1'b0, 1'b0);
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    check("frm_valid", out_valid, 1);
    check("frm_data",  out_data,  -5);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("frm_clr", frame_err, 0);

    // Stray slice in IDLE is dropped
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    check("stray_ferr",  frame_err, 1);
    check("stray_valid", out_valid, 0);
    sample_24();
    check("stray_data", out_data, 24);
    tick();

    // err_clr beats a simultaneous set
    err_clr = 1'b1;
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("clr_prio", frame_err, 0);

    // Asynchronous reset mid-sample
    out_ready = 1'b0;
    sample_24();
    slice(4'd1, 4'd0, 1'b0, 1'b0);
    slice(4'd1, 4'd0, 1'b0, 1'b1);
    slice(4'd0, 4'd0, 1'b0, 1'b0);
    check("prerst_valid", out_valid, 1);
    check("prerst_ferr",  frame_err, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data",  out_data,  0);
    check("arst_ovr",   ovr,       0);
    check("arst_ferr",  frame_err, 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    sample_24();
    check("postrst_valid", out_valid, 1);
    check("postrst_data",  out_data,  24);
    check("postrst_ferr",  frame_err, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/da_shift_acc.md
DA_SHIFT_ACC -- requirements
Module: da_shift_acc

Interface
REQ-001 Parameter IN_W, default 16, width of the carry-save slice inputs from the 4:2 compressor stage; SHALL be >= 4.
REQ-002 Parameter NBITS, default 16, number of bit-slices per output sample; SHALL be >= 2.
REQ-003 Localparam OUT_W = IN_W + NBITS + 2, width of the result.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_in  input  IN_W  registered sum word from the compressor stage.
REQ-007 c_in  input  IN_W  registered carry word from the compressor stage.
REQ-008 cout_in  input  1  registered top carry-out from the compressor stage.
REQ-009 in_valid  input  1  slice qualifier; no input backpressure exists.
REQ-010 in_first  input  1  marks the first slice of a sample, which is the MSB (sign) slice; sampled only with in_valid.
REQ-011 out_data  output  OUT_W  signed two's-complement result.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-014 ovr  output  1  sticky: a result was overwritten before acceptance.
REQ-015 frame_err  output  1  sticky: a framing violation occurred.
REQ-016 err_clr  input  1  synchronous clear of ovr and frame_err.

Function
REQ-017 Slice value V = s_in + 2*c_in + cout_in*2^IN_W, unsigned, zero-extended to OUT_W.
REQ-018 Slices arrive MSB first; result y = -V[NBITS-1]*2^(NBITS-1) + sum over b < NBITS-1 of V[b]*2^b, exact, no saturation.
REQ-019 State machine with states IDLE and ACC; slice counter cnt of ceil(log2(NBITS)) bits.
REQ-020 IDLE, in_valid && in_first: acc <= -V, cnt <= 1, go to ACC.
REQ-021 IDLE, in_valid && !in_first: drop the slice, set frame_err, stay in IDLE.
REQ-022 ACC, in_valid && !in_first: acc <= 2*acc + V, cnt <= cnt+1.
REQ-023 ACC, in_valid && in_first: abort the current sample, set frame_err, restart as in REQ-020.
REQ-024 ACC, in_valid low: hold acc, cnt and state; gaps of any length are allowed.
REQ-025 When the slice with cnt == NBITS-1 is accepted, 2*acc + V SHALL be loaded into out_data on the same edge. State goes to IDLE. out_valid is high from the next cycle (latency 1 cycle after the last slice).
REQ-026 out_valid and out_data SHALL hold until a cycle with out_valid && out_ready; out_valid then deasserts unless a new result loads on the same edge.
REQ-027 New result loads while out_valid && !out_ready: overwrite out_data, keep out_valid high, set ovr.
REQ-028 New result loads with out_valid && out_ready in the same cycle: out_valid stays high with the new data, ovr unchanged.
REQ-029 err_clr has priority over a simultaneous set event in the same cycle; the flags end that cycle at 0.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, cnt 0, acc 0, out_data 0, out_valid 0, ovr 0, frame_err 0.
REQ-031 A reset mid-sample SHALL discard the partial sample; the first slice after release SHALL have in_first set or REQ-021 applies.

Structure
REQ-032 Shared package da_fir_pkg SHALL hold the state encoding, OUT_W derivation and the NBITS/IN_W defaults used across the filter.
REQ-033 One combinational sub-module, da_cs_resolve, SHALL compute V from s_in, c_in and cout_in (REQ-017); the rest is flat.

Verification (bench uses IN_W=4, NBITS=4)
REQ-034 Slices with S=1,0,1,1 and C=0, cout=0, first flag on slice 1, back-to-back, out_ready=1 -> out_data=-5, out_valid for 1 cycle, one cycle after the 4th slice.
REQ-035 Slice (S=3,C=1,cout=0) -> V=5; slice (S=0,C=0,cout=1) -> V=16; sequence 5,16,0,0 -> y=-40+64=24.
REQ-036 Same sample as REQ-034 with 3 idle cycles between each slice -> out_data=-5, no errors.
REQ-037 out_ready=0, two complete samples (-5 then 24) -> out_data=24, out_valid=1, ovr=1; err_clr -> ovr=0.
REQ-038 in_first reasserted on the 3rd slice -> frame_err=1; following 4 slices produce the correct result. A slice without in_first in IDLE -> dropped, frame_err=1.
REQ-039 rst_n pulsed low after 2 slices -> all outputs 0 immediately; a fresh 4-slice sample after release -> correct y.
